// File: rtl/ysyx_24100006_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24100006_mem_access
// Purpose  : MEM pipeline stage. Converts load/store micro-ops into single-beat
//            data-bus transactions (store data/strobe alignment, load byte/half
//            selection with sign/zero extension). Non-memory ops pass through
//            with one cycle of latency; upstream is stalled while a bus
//            transfer is outstanding.
// Ports    : clk, reset (async, active-high)
//            in_valid/in_ready, addr_i, wdata_i, wmask_i, rmask_i, rw_i, pt_i,
//            flush_i                                  -- from EXE/MEM register
//            bus_req_valid/ready, bus_addr, bus_wen, bus_wdata, bus_wstrb,
//            bus_rsp_valid, bus_rdata, bus_rsp_err    -- data bus
//            out_valid/out_ready, load_data_o, pt_o, exc_o -- to MEM/WB register
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_24100006_mem_access #(
  parameter int PT_W = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     addr_i,
  input  logic [31:0]     wdata_i,
  input  logic [7:0]      wmask_i,
  input  logic [2:0]      rmask_i,
  input  logic [1:0]      rw_i,
  input  logic [PT_W-1:0] pt_i,
  input  logic            flush_i,
  output logic            bus_req_valid,
  input  logic            bus_req_ready,
  output logic [31:0]     bus_addr,
  output logic            bus_wen,
  output logic [31:0]     bus_wdata,
  output logic [3:0]      bus_wstrb,
  input  logic            bus_rsp_valid,
  input  logic [31:0]     bus_rdata,
  input  logic            bus_rsp_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     load_data_o,
  output logic [PT_W-1:0] pt_o,
  output logic [1:0]      exc_o
);

  localparam logic [1:0] C_EXC_OK  = 2'b00;
  localparam logic [1:0] C_EXC_MIS = 2'b01;
  localparam logic [1:0] C_EXC_BUS = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t          r_state;
  logic [1:0]      r_addr_lo;
  logic [2:0]      r_rmask;
  logic            r_is_load;
  logic            r_kill;      // flushed while the bus transfer was in flight
  logic [31:0]     r_load_data;
  logic [PT_W-1:0] r_pt;
  logic [1:0]      r_exc;
  logic [31:0]     r_bus_addr;
  logic            r_bus_wen;
  logic [31:0]     r_bus_wdata;
  logic [3:0]      r_bus_wstrb;

  logic            w_is_load;
  logic            w_is_store;
  logic            w_half;
  logic            w_word;
  logic            w_misaligned;
  logic            w_take;
  logic [31:0]     w_rsp_shift;
  logic [31:0]     w_rsp_ext;
  logic            w_unused_wmask_hi;

  assign w_unused_wmask_hi = ^wmask_i[7:4];

  assign in_ready      = (r_state == S_IDLE) || ((r_state == S_HOLD) && out_ready);
  // A flush in the same cycle wins over a new op.
  assign w_take        = in_valid && in_ready && !flush_i;
  assign out_valid     = (r_state == S_HOLD);
  assign bus_req_valid = (r_state == S_REQ);
  assign bus_addr      = r_bus_addr;
  assign bus_wen       = r_bus_wen;
  assign bus_wdata     = r_bus_wdata;
  assign bus_wstrb     = r_bus_wstrb;
  assign load_data_o   = r_load_data;
  assign pt_o          = r_pt;
  assign exc_o         = r_exc;

  // Access size decode. A load whose rmask names no size is handled as LW.
  always_comb begin
    w_is_load  = (rw_i == 2'b01);
    w_is_store = (rw_i == 2'b10);
    w_half     = 1'b0;
    w_word     = 1'b0;
    if (w_is_load) begin
      w_half = (rmask_i == 3'b011) || (rmask_i == 3'b100);
      w_word = !w_half && (rmask_i != 3'b001) && (rmask_i != 3'b010);
    end else if (w_is_store) begin
      w_word = |wmask_i[3:2];
      w_half = !w_word && wmask_i[1];
    end
    w_misaligned = (w_half && addr_i[0]) || (w_word && (addr_i[1:0] != 2'b00));
  end

  // Load extraction: shift the addressed byte/half down to bit 0, then extend.
  always_comb begin
    w_rsp_shift = bus_rdata >> {r_addr_lo, 3'b000};
    case (r_rmask)
      3'b001:  w_rsp_ext = {{24{w_rsp_shift[7]}}, w_rsp_shift[7:0]};
      3'b010:  w_rsp_ext = {24'b0, w_rsp_shift[7:0]};
      3'b011:  w_rsp_ext = {{16{w_rsp_shift[15]}}, w_rsp_shift[15:0]};
      3'b100:  w_rsp_ext = {16'b0, w_rsp_shift[15:0]};
      default: w_rsp_ext = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_addr_lo   <= 2'b00;
      r_rmask     <= 3'b000;
      r_is_load   <= 1'b0;
      r_kill      <= 1'b0;
      r_load_data <= 32'b0;
      r_pt        <= '0;
      r_exc       <= C_EXC_OK;
      r_bus_addr  <= 32'b0;
      r_bus_wen   <= 1'b0;
      r_bus_wdata <= 32'b0;
      r_bus_wstrb <= 4'b0;
    end else if (w_take) begin
      // Capture from IDLE, or directly from HOLD as the result drains.
      r_pt        <= pt_i;
      r_addr_lo   <= addr_i[1:0];
      r_rmask     <= rmask_i;
      r_is_load   <= w_is_load;
      r_kill      <= 1'b0;
      r_load_data <= 32'b0;
      if (!(w_is_load || w_is_store)) begin
        r_state <= S_HOLD;
        r_exc   <= C_EXC_OK;
      end else if (w_misaligned) begin
        r_state <= S_HOLD;
        r_exc   <= C_EXC_MIS;
      end else begin
        r_state     <= S_REQ;
        r_exc       <= C_EXC_OK;
        r_bus_addr  <= {addr_i[31:2], 2'b00};
        r_bus_wen   <= w_is_store;
        r_bus_wdata <= wdata_i << {addr_i[1:0], 3'b000};
        r_bus_wstrb <= w_is_store ? (wmask_i[3:0] << addr_i[1:0]) : 4'b0000;
      end
    end else begin
      case (r_state)
        S_REQ: begin
          // The request cannot be withdrawn; a flush only marks it dead.
          if (flush_i)       r_kill  <= 1'b1;
          if (bus_req_ready) r_state <= S_RESP;
        end
        S_RESP: begin
          if (bus_rsp_valid) begin
            r_kill <= 1'b0;
            if (r_kill || flush_i) begin
              r_state <= S_IDLE;
            end else begin
              r_state     <= S_HOLD;
              r_load_data <= (r_is_load && !bus_rsp_err) ? w_rsp_ext : 32'b0;
              r_exc       <= bus_rsp_err ? C_EXC_BUS : C_EXC_OK;
            end
          end else if (flush_i) begin
            r_kill <= 1'b1;
          end
        end
        S_HOLD: begin
          if (flush_i || out_ready) r_state <= S_IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
